path_arbiter: RTL and testbench

- Consumer end of the path req/gnt interface.
- Collects req_o/data_o from NUM_PATHS path instances.
- Issues one-hot grants using round-robin with bounded bursts, and registers the granted word into a single output stage with valid/ready handshake to downstream.
- The grant pops the winning path's FIFO (or bypass) in the same cycle.

---
 rtl/path_pkg.sv | 38 +++
 rtl/rr_select.sv | 26 ++
 rtl/path_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_path_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/path_pkg.sv
// Shared types and the round-robin pick helper for the path arbiter family.
package path_pkg;

  localparam int unsigned NUM_PATHS_DEF = 4;
  localparam int unsigned PWIDTH        = $clog2(NUM_PATHS_DEF);
  localparam int unsigned BCNT_WIDTH    = 4;
  localparam int unsigned PICK_W        = 16;
  localparam int unsigned PICK_IW       = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  typedef struct packed {
    logic               found;
    logic [PICK_IW-1:0] idx;
  } pick_t;

  // First requesting, unmasked index at or after ptr, wrapping modulo n (n <= 16).
  function automatic pick_t rr_pick(input logic [PICK_W-1:0]  req,
                                    input logic [PICK_IW-1:0] ptr,
                                    input logic [PICK_W-1:0]  mask,
                                    input int unsigned        n);
    pick_t       res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 0; i < PICK_W; i++) begin
      j = (32'(ptr) + i) % n;
      if (i < n && !res.found && req[j[PICK_IW-1:0]] && !mask[j[PICK_IW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = PICK_IW'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational masked round-robin picker: one-hot grant, index and found flag.
module rr_select
  import path_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  input  logic [N-1:0]         i_mask,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_found
);

  localparam int unsigned IW = $clog2(N);

  pick_t w_pick;

  always_comb begin
    w_pick  = rr_pick(PICK_W'(i_req), PICK_IW'(i_ptr), PICK_W'(i_mask), N);
    o_found = w_pick.found;
    o_idx   = IW'(w_pick.idx);
    o_gnt   = w_pick.found ? (N'(1) << w_pick.idx) : '0;
  end

endmodule

// File: rtl/path_arbiter.sv
// Round-robin, burst-bounded consumer of NUM_PATHS path req/gnt interfaces with a
// registered valid/ready output stage. Define ARB_STATS_EN for grant counters and starvation flags.
module path_arbiter
  import path_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned NUM_PATHS = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PATHS-1:0]          req_i,
  input  logic [NUM_PATHS*DWIDTH-1:0]   data_i,
  input  logic                          flush_i,
  input  logic                          ready_i,
  output logic [NUM_PATHS-1:0]          gnt_o,
  output logic                          valid_o,
  output logic [DWIDTH-1:0]             data_o,
  output logic [$clog2(NUM_PATHS)-1:0]  src_o
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_PATHS*16-1:0]       grant_cnt_o,
  output logic [NUM_PATHS-1:0]          starve_o
`endif
);

  localparam int unsigned PW = $clog2(NUM_PATHS);

  arb_state_t              r_state;
  logic [PW-1:0]           r_owner;
  logic [PW-1:0]           r_ptr;
  logic [BCNT_WIDTH-1:0]   r_cnt;
  logic                    r_valid;
  logic [DWIDTH-1:0]       r_data;
  logic [PW-1:0]           r_src;

  logic                    w_take;
  logic                    w_owner_req;
  logic                    w_cnt_full;
  logic                    w_keep;
  logic                    w_rotate;
  logic [PW-1:0]           w_owner_nxt;
  logic [PW-1:0]           w_sel_ptr;
  logic [NUM_PATHS-1:0]    w_mask;
  logic [NUM_PATHS-1:0]    w_pick_oh;
  logic [PW-1:0]           w_pick_idx;
  logic                    w_pick_found;
  logic                    w_win;
  logic                    w_restart;
  logic [PW-1:0]           w_win_idx;
  logic [NUM_PATHS-1:0]    w_win_oh;
  logic                    w_grant;
  logic [NUM_PATHS-1:0]    w_gnt;
  logic [DWIDTH-1:0]       w_win_data;

  assign w_take      = !r_valid || ready_i;
  assign w_owner_req = req_i[r_owner];
  assign w_cnt_full  = (r_cnt >= BCNT_WIDTH'(MAX_BURST));
  assign w_keep      = (r_state == ARB_BURST) && w_owner_req && !w_cnt_full;
  assign w_rotate    = (r_state == ARB_BURST) && !w_keep;
  assign w_owner_nxt = (r_owner == PW'(NUM_PATHS - 1)) ? '0 : r_owner + PW'(1);
  assign w_sel_ptr   = w_rotate ? w_owner_nxt : r_ptr;
  // An exhausted owner sits out this search; it is re-granted below only if nobody else asks.
  assign w_mask      = (w_rotate && w_cnt_full) ? (NUM_PATHS'(1) << r_owner) : '0;

  rr_select #(
    .N (NUM_PATHS)
  ) u_rr_select (
    .i_req   (req_i),
    .i_ptr   (w_sel_ptr),
    .i_mask  (w_mask),
    .o_gnt   (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // Winner selection: continue burst, new round-robin winner, or lone exhausted owner.
  always_comb begin
    w_win     = 1'b0;
    w_restart = 1'b0;
    w_win_idx = r_owner;
    w_win_oh  = NUM_PATHS'(1) << r_owner;
    if (w_keep) begin
      w_win = 1'b1;
    end else if (w_pick_found) begin
      w_win     = 1'b1;
      w_restart = 1'b1;
      w_win_idx = w_pick_idx;
      w_win_oh  = w_pick_oh;
    end else if (w_rotate && w_owner_req) begin
      w_win     = 1'b1;
      w_restart = 1'b1;
    end
  end

  assign w_grant = w_win && w_take && !flush_i;
  assign w_gnt   = w_grant ? w_win_oh : '0;
  assign gnt_o   = rst ? '0 : w_gnt;

  always_comb begin
    w_win_data = '0;
    for (int unsigned i = 0; i < NUM_PATHS; i++) begin
      if (w_win_idx == PW'(i)) w_win_data = data_i[i*DWIDTH +: DWIDTH];
    end
  end

  // Arbitration FSM and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_state <= ARB_IDLE;
      r_cnt   <= '0;
    end else if (w_take) begin
      if (w_rotate) r_ptr <= w_owner_nxt;
      if (w_grant) begin
        r_valid <= 1'b1;
        r_data  <= w_win_data;
        r_src   <= w_win_idx;
        r_owner <= w_win_idx;
        r_state <= ARB_BURST;
        r_cnt   <= w_restart ? BCNT_WIDTH'(1) : r_cnt + BCNT_WIDTH'(1);
      end else begin
        r_valid <= 1'b0;
        r_state <= ARB_IDLE;
        r_cnt   <= '0;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign src_o   = r_src;

`ifdef ARB_STATS_EN
  localparam int unsigned STARVE_LIM = NUM_PATHS * MAX_BURST;

  logic [15:0]          r_gcnt [NUM_PATHS];
  logic [7:0]           r_wait [NUM_PATHS];
  logic [NUM_PATHS-1:0] r_starve;

  // Saturating grant counters and sticky starvation detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PATHS; i++) begin
        r_gcnt[i] <= '0;
        r_wait[i] <= '0;
      end
      r_starve <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < NUM_PATHS; i++) begin
        r_gcnt[i] <= '0;
        r_wait[i] <= '0;
      end
      r_starve <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PATHS; i++) begin
        if (w_gnt[i] && r_gcnt[i] != 16'hFFFF) r_gcnt[i] <= r_gcnt[i] + 16'd1;
        if (!req_i[i] || w_gnt[i]) begin
          r_wait[i] <= '0;
        end else if (w_take && r_wait[i] != 8'hFF) begin
          r_wait[i] <= r_wait[i] + 8'd1;
        end
        if (w_take && req_i[i] && !w_gnt[i] && r_wait[i] >= 8'(STARVE_LIM)) r_starve[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int unsigned i = 0; i < NUM_PATHS; i++) grant_cnt_o[i*16 +: 16] = r_gcnt[i];
  end

  assign starve_o = r_starve;
`endif

endmodule

// File: tb/tb_path_arbiter.sv
// Scoreboard bench for path_arbiter: directed grant vectors, queued expected words.
module tb_path_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 4;
  localparam int unsigned MB = 4;
  localparam int unsigned PW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_i;
  logic [NP*DW-1:0]  data_i;
  logic              flush_i;
  logic              ready_i;
  logic [NP-1:0]     gnt_o;
  logic              valid_o;
  logic [DW-1:0]     data_o;
  logic [PW-1:0]     src_o;
`ifdef ARB_STATS_EN
  logic [NP*16-1:0]  grant_cnt_o;
  logic [NP-1:0]     starve_o;
`endif

  typedef struct packed {
    logic [PW-1:0] src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  path_arbiter #(
    .DWIDTH    (DW),
    .NUM_PATHS (NP),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .data_i      (data_i),
    .flush_i     (flush_i),
    .ready_i     (ready_i),
    .gnt_o       (gnt_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .src_o       (src_o)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt_o (grant_cnt_o),
    .starve_o    (starve_o)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the edge, check gnt_o mid-cycle, queue the word it should capture.
  task automatic step(input logic [NP-1:0] req, input logic rdy, input logic fl,
                      input logic [31:0] d, input logic [NP-1:0] exp_gnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    req_i   = req;
    ready_i = rdy;
    flush_i = fl;
    data_i  = d;
    #3;
    chk(nm, 32'(gnt_o), 32'(exp_gnt));
    for (int k = 0; k < NP; k++) begin
      if (exp_gnt[k]) begin
        e.src  = PW'(k);
        e.data = d[k*DW +: DW];
        q.push_back(e);
      end
    end
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk({nm, "_valid"}, 32'(valid_o), 32'd0);
    chk({nm, "_data"},  32'(data_o),  32'd0);
    chk({nm, "_gnt"},   32'(gnt_o),   32'd0);
    q.delete();
    @(posedge clk);
    #1;
    req_i   = '0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    rst     = 1'b0;
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got word %0h src %0d with empty queue", data_o, src_o);
      end else begin
        m_e = q.pop_front();
        chk("sb_data", 32'(data_o), 32'(m_e.data));
        chk("sb_src",  32'(src_o),  32'(m_e.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g [17];
    logic [31:0] d;
    logic [7:0]  hold;

    rst     = 1'b1;
    req_i   = '0;
    flush_i = 1'b0;
    ready_i = 1'b1;
    data_i  = 32'hD3C2A5B0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data",  32'(data_o),  32'd0);
    chk("rst_src",   32'(src_o),   32'd0);
    chk("rst_gnt",   32'(gnt_o),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester: path 1 keeps winning across the burst boundary.
    for (int i = 0; i < 6; i++) step(4'b0010, 1'b1, 1'b0, 32'hD3C2A5B0, 4'b0010, "single");
    step(4'b0000, 1'b1, 1'b0, 32'hD3C2A5B0, 4'b0000, "single_drop");
    step(4'b0000, 1'b1, 1'b0, 32'hD3C2A5B0, 4'b0000, "idle");
    chk("idle_valid", 32'(valid_o), 32'd0);

    // Full contention from reset.
    do_reset("rst2");
    g = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    for (int i = 0; i < 17; i++) begin
      d = 32'hD3C2A5B0 ^ {4{8'(i)}};
      step(4'b1111, 1'b1, 1'b0, d, 4'(1 << g[i]), "contend");
    end

    // Backpressure: owner 0 at cnt 2, then stalled for 3 cycles.
    d = 32'h44332211;
    step(4'b1111, 1'b1, 1'b0, d, 4'b0001, "bp_pre");
    hold = d[7:0];
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 1'b0, 32'h99887766 + 32'(i), 4'b0000, "bp_hold_gnt");
      chk("bp_hold_valid", 32'(valid_o), 32'd1);
      chk("bp_hold_data",  32'(data_o),  32'(hold));
      chk("bp_hold_src",   32'(src_o),   32'd0);
    end
    step(4'b1111, 1'b1, 1'b0, 32'h5A6B7C8D, 4'b0001, "bp_resume");
    step(4'b1111, 1'b1, 1'b0, 32'h1F2E3D4C, 4'b0001, "bp_resume");
    step(4'b1111, 1'b1, 1'b0, 32'h0A0B0C0D, 4'b0010, "bp_rotate");

    // Requester drops mid-burst: hand-off to path 3 with no bubble.
    do_reset("rst3");
    step(4'b1100, 1'b1, 1'b0, 32'hCAFEBABE, 4'b0100, "drop_a");
    step(4'b1100, 1'b1, 1'b0, 32'hDEADBEEF, 4'b0100, "drop_a");
    step(4'b1000, 1'b1, 1'b0, 32'h12345678, 4'b1000, "drop_b");
    step(4'b1000, 1'b1, 1'b0, 32'h87654321, 4'b1000, "drop_b");

    // Flush with a word held: no grant that cycle, empty stage next, fresh burst to path 0.
    chk("pre_flush_valid", 32'(valid_o), 32'd1);
    step(4'b0001, 1'b1, 1'b1, 32'h0000005E, 4'b0000, "flush_gnt");
    step(4'b0011, 1'b1, 1'b0, 32'h0000E761, 4'b0001, "post_flush");
    chk("post_flush_valid", 32'(valid_o), 32'd0);
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b1, 1'b0, 32'h0000E761 + 32'(i), 4'b0001, "post_flush_burst");
    step(4'b0011, 1'b1, 1'b0, 32'h0000B2C3, 4'b0010, "post_flush_rot");

    // Async reset mid-burst with a word in flight, then restart from pointer 0.
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    do_reset("rst4");
    step(4'b1110, 1'b1, 1'b0, 32'h76543210, 4'b0010, "after_rst");
    step(4'b1111, 1'b1, 1'b0, 32'h76543211, 4'b0010, "after_rst");

    step(4'b0000, 1'b1, 1'b0, 32'h0, 4'b0000, "drain");
    step(4'b0000, 1'b1, 1'b0, 32'h0, 4'b0000, "drain");
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
